// File: rtl/ps2_key_sequencer.sv
// ============================================================================
// Module      : ps2_key_sequencer
// Description : Drains PS/2 set-2 scan codes from the receiver FIFO, resolves
//               E0/F0 prefixes, tracks Shift/CapsLock and emits one ASCII key
//               event per make/break over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_key_sequencer #(
   parameter int         POP_GAP     = 2,
   parameter logic [7:0] CAPS_CODE   = 8'h58,
   parameter logic [7:0] LSHIFT_CODE = 8'h12,
   parameter logic [7:0] RSHIFT_CODE = 8'h59
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic [7:0] kb_data,
   input  logic       kb_ready,
   input  logic       kb_overflow,
   output logic       nextdata_n,
   output logic [7:0] rom_addr,
   input  logic [7:0] rom_q,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic [7:0] ev_code,
   output logic [7:0] ev_ascii,
   output logic       ev_make,
   output logic       ev_ext,
   output logic       caps_lock,
   output logic       shift,
   output logic [7:0] make_count,
   output logic       ovf_err,
   input  logic       err_clr
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_POP      = 3'd1,
      ST_GAP      = 3'd2,
      ST_DECODE   = 3'd3,
      ST_ROM_WAIT = 3'd4,
      ST_ROM_DATA = 3'd5,
      ST_EMIT     = 3'd6
   } state_t;

   localparam int            C_GW       = (POP_GAP > 1) ? $clog2(POP_GAP) : 1;
   localparam logic [C_GW-1:0] C_GAP_LAST = C_GW'(POP_GAP - 1);
   localparam logic [7:0]    C_PFX_EXT  = 8'hE0;
   localparam logic [7:0]    C_PFX_BRK  = 8'hF0;

   state_t          r_state;
   state_t          w_next;
   logic [7:0]      r_byte;
   logic [C_GW-1:0] r_gap_cnt;
   logic            r_ext_f;
   logic            r_brk_f;
   logic            r_lshift;
   logic            r_rshift;
   logic            r_caps;
   logic            r_caps_held;
   logic            r_caps_lock;
   logic            r_shift;
   logic [7:0]      r_rom_addr;
   logic [7:0]      r_ev_code;
   logic [7:0]      r_ev_ascii;
   logic            r_ev_make;
   logic            r_ev_ext;
   logic [7:0]      r_make_count;
   logic            r_ovf_err;

   logic            w_nextdata_n;
   logic            w_ev_valid;
   logic            w_is_prefix;
   logic            w_make;
   logic            w_rom_lookup;
   logic            w_is_lower;
   logic [7:0]      w_ascii;

   assign w_is_prefix  = (r_byte == C_PFX_EXT) || (r_byte == C_PFX_BRK);
   assign w_make       = ~r_brk_f;
   assign w_rom_lookup = w_make & ~r_ext_f;
   assign w_is_lower   = (rom_q >= 8'h61) && (rom_q <= 8'h7A);
   assign w_ascii      = (w_is_lower && (r_shift ^ r_caps_lock)) ? (rom_q - 8'h20) : rom_q;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_nextdata_n = 1'b1;
      w_ev_valid   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (kb_ready) w_next = ST_POP;
         end
         ST_POP: begin
            w_nextdata_n = 1'b0;
            w_next       = ST_GAP;
         end
         ST_GAP: begin
            if (r_gap_cnt == C_GAP_LAST) w_next = ST_DECODE;
         end
         ST_DECODE: begin
            if (w_is_prefix)       w_next = ST_IDLE;
            else if (w_rom_lookup) w_next = ST_ROM_WAIT;
            else                   w_next = ST_EMIT;
         end
         ST_ROM_WAIT: w_next = ST_ROM_DATA;
         ST_ROM_DATA: w_next = ST_EMIT;
         ST_EMIT: begin
            w_ev_valid = 1'b1;
            if (ev_ready) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_byte       <= 8'h00;
         r_gap_cnt    <= '0;
         r_ext_f      <= 1'b0;
         r_brk_f      <= 1'b0;
         r_lshift     <= 1'b0;
         r_rshift     <= 1'b0;
         r_caps       <= 1'b0;
         r_caps_held  <= 1'b0;
         r_caps_lock  <= 1'b0;
         r_shift      <= 1'b0;
         r_rom_addr   <= 8'h00;
         r_ev_code    <= 8'h00;
         r_ev_ascii   <= 8'h00;
         r_ev_make    <= 1'b0;
         r_ev_ext     <= 1'b0;
         r_make_count <= 8'h00;
         r_ovf_err    <= 1'b0;
      end else begin
         // Modifier outputs trail the internal modifier state by one clock.
         r_shift     <= r_lshift | r_rshift;
         r_caps_lock <= r_caps;

         case (r_state)
            ST_IDLE: begin
               if (kb_ready) r_byte <= kb_data;
            end
            ST_POP: r_gap_cnt <= '0;
            ST_GAP: r_gap_cnt <= r_gap_cnt + 1'b1;
            ST_DECODE: begin
               if (r_byte == C_PFX_EXT) begin
                  r_ext_f <= 1'b1;
               end else if (r_byte == C_PFX_BRK) begin
                  r_brk_f <= 1'b1;
               end else begin
                  r_ev_code <= r_byte;
                  r_ev_make <= w_make;
                  r_ev_ext  <= r_ext_f;
                  if (w_rom_lookup) r_rom_addr <= r_byte;
                  else              r_ev_ascii <= 8'h00;
                  if (!r_ext_f) begin
                     if (r_byte == LSHIFT_CODE) r_lshift <= w_make;
                     if (r_byte == RSHIFT_CODE) r_rshift <= w_make;
                     // caps_held blocks typematic repeats from re-toggling.
                     if (r_byte == CAPS_CODE) begin
                        if (w_make && !r_caps_held) begin
                           r_caps      <= ~r_caps;
                           r_caps_held <= 1'b1;
                        end else if (!w_make) begin
                           r_caps_held <= 1'b0;
                        end
                     end
                  end
               end
            end
            ST_ROM_DATA: r_ev_ascii <= w_ascii;
            ST_EMIT: begin
               if (ev_ready) begin
                  r_ext_f <= 1'b0;
                  r_brk_f <= 1'b0;
                  if (r_ev_make) r_make_count <= r_make_count + 8'd1;
               end
            end
            default: ;
         endcase

         if (err_clr) r_ovf_err <= 1'b0;
         // Overflow corrupts any partial prefix sequence; it wins over err_clr.
         if (kb_overflow) begin
            r_ovf_err <= 1'b1;
            r_ext_f   <= 1'b0;
            r_brk_f   <= 1'b0;
         end
      end
   end

   assign nextdata_n = w_nextdata_n;
   assign ev_valid   = w_ev_valid;
   assign rom_addr   = r_rom_addr;
   assign ev_code    = r_ev_code;
   assign ev_ascii   = r_ev_ascii;
   assign ev_make    = r_ev_make;
   assign ev_ext     = r_ev_ext;
   assign caps_lock  = r_caps_lock;
   assign shift      = r_shift;
   assign make_count = r_make_count;
   assign ovf_err    = r_ovf_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_sequencer.sv
// ============================================================================
// Module      : tb_ps2_key_sequencer
// Description : Directed self-checking bench with a FIFO and ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_key_sequencer;

   logic       clk = 1'b0;
   logic       clrn;
   logic [7:0] kb_data;
   logic       kb_ready;
   logic       kb_overflow;
   logic       nextdata_n;
   logic [7:0] rom_addr;
   logic [7:0] rom_q = 8'h00;
   logic       ev_valid;
   logic       ev_ready;
   logic [7:0] ev_code;
   logic [7:0] ev_ascii;
   logic       ev_make;
   logic       ev_ext;
   logic       caps_lock;
   logic       shift;
   logic [7:0] make_count;
   logic       ovf_err;
   logic       err_clr;

   always #5 clk = ~clk;

   ps2_key_sequencer dut (
      .clk        (clk),
      .clrn       (clrn),
      .kb_data    (kb_data),
      .kb_ready   (kb_ready),
      .kb_overflow(kb_overflow),
      .nextdata_n (nextdata_n),
      .rom_addr   (rom_addr),
      .rom_q      (rom_q),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_code    (ev_code),
      .ev_ascii   (ev_ascii),
      .ev_make    (ev_make),
      .ev_ext     (ev_ext),
      .caps_lock  (caps_lock),
      .shift      (shift),
      .make_count (make_count),
      .ovf_err    (ovf_err),
      .err_clr    (err_clr)
   );

   // Receiver FIFO model
   logic [7:0] fifo_mem [32];
   logic [7:0] wp = 8'd0;
   logic [7:0] rp = 8'd0;
   int         n_pops = 0;
   assign kb_ready = (wp != rp);
   assign kb_data  = fifo_mem[rp[4:0]];
   always @(posedge clk) begin
      if (!nextdata_n) begin
         rp     <= rp + 8'd1;
         n_pops <= n_pops + 1;
      end
   end

   // Synchronous scan-code ROM model
   logic [7:0] rom [256];
   always @(posedge clk) rom_q <= rom[rom_addr];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      fifo_mem[wp[4:0]] = b;
      wp = wp + 8'd1;
   endtask

   task automatic exp_ev(input string tag, input logic [7:0] code, input logic mk,
                         input logic ext, input logic [7:0] ascii, output int lat);
      lat = 0;
      while (!ev_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " valid"}, ev_valid, 1'b1);
      chk({tag, " code"},  ev_code,  code);
      chk({tag, " make"},  ev_make,  mk);
      chk({tag, " ext"},   ev_ext,   ext);
      chk({tag, " ascii"}, ev_ascii, ascii);
      if (ev_ready) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int p0;
      int lows;
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
      rom[8'h1C] = 8'h61;
      rom[8'h16] = 8'h31;
      clrn = 1'b0; ev_ready = 1'b1; kb_overflow = 1'b0; err_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst nextdata_n", nextdata_n, 1'b1);
      chk("rst ev_valid",   ev_valid,   1'b0);
      chk("rst ev_code",    ev_code,    8'h00);
      chk("rst make_count", make_count, 8'h00);
      chk("rst caps",       caps_lock,  1'b0);
      chk("rst ovf_err",    ovf_err,    1'b0);
      clrn = 1'b1;
      @(negedge clk);

      // Plain make with full latency
      p0 = n_pops;
      push(8'h1C);
      exp_ev("A make", 8'h1C, 1'b1, 1'b0, 8'h61, lat);
      chk("A latency", lat, 7);
      chk("A pops", n_pops - p0, 1);
      chk("A make_count", make_count, 8'd1);
      chk("A rom_addr", rom_addr, 8'h1C);

      // Break sequence: one event, no count
      p0 = n_pops;
      push(8'hF0); push(8'h1C);
      exp_ev("A break", 8'h1C, 1'b0, 1'b0, 8'h00, lat);
      repeat (10) @(negedge clk);
      chk("brk no extra event", ev_valid, 1'b0);
      chk("brk pops", n_pops - p0, 2);
      chk("brk make_count", make_count, 8'd1);

      // Shift
      push(8'h12); push(8'h1C); push(8'hF0); push(8'h1C); push(8'hF0); push(8'h12);
      exp_ev("LSH make", 8'h12, 1'b1, 1'b0, 8'h00, lat);
      exp_ev("shA make", 8'h1C, 1'b1, 1'b0, 8'h41, lat);
      chk("shift held", shift, 1'b1);
      exp_ev("shA break", 8'h1C, 1'b0, 1'b0, 8'h00, lat);
      exp_ev("LSH break", 8'h12, 1'b0, 1'b0, 8'h00, lat);
      repeat (2) @(negedge clk);
      chk("shift released", shift, 1'b0);
      chk("shift make_count", make_count, 8'd3);

      // CapsLock with typematic repeat
      push(8'h58); push(8'h58); push(8'hF0); push(8'h58); push(8'h1C);
      exp_ev("caps make", 8'h58, 1'b1, 1'b0, 8'h00, lat);
      chk("caps on", caps_lock, 1'b1);
      exp_ev("caps repeat", 8'h58, 1'b1, 1'b0, 8'h00, lat);
      chk("caps repeat ignored", caps_lock, 1'b1);
      exp_ev("caps break", 8'h58, 1'b0, 1'b0, 8'h00, lat);
      exp_ev("capsA make", 8'h1C, 1'b1, 1'b0, 8'h41, lat);
      push(8'h12); push(8'h1C); push(8'hF0); push(8'h12);
      exp_ev("capsLSH make", 8'h12, 1'b1, 1'b0, 8'h00, lat);
      exp_ev("capsShA make", 8'h1C, 1'b1, 1'b0, 8'h61, lat);
      exp_ev("capsLSH break", 8'h12, 1'b0, 1'b0, 8'h00, lat);
      chk("caps make_count", make_count, 8'd8);

      // Extended key: no ROM lookup
      push(8'hE0); push(8'h75);
      exp_ev("ext make", 8'h75, 1'b1, 1'b1, 8'h00, lat);
      push(8'hE0); push(8'hF0); push(8'h75);
      exp_ev("ext break", 8'h75, 1'b0, 1'b1, 8'h00, lat);
      chk("ext rom_addr", rom_addr, 8'h1C);
      chk("ext make_count", make_count, 8'd9);

      // Backpressure, overflow, error clear
      ev_ready = 1'b0;
      p0 = n_pops;
      push(8'h16); push(8'h1C); push(8'h16);
      exp_ev("bp make", 8'h16, 1'b1, 1'b0, 8'h31, lat);
      lows = 0;
      repeat (10) begin
         @(negedge clk);
         if (!nextdata_n) lows++;
      end
      chk("bp no pop strobe", lows, 0);
      chk("bp pops", n_pops - p0, 1);
      chk("bp valid held", ev_valid, 1'b1);
      chk("bp code held", ev_code, 8'h16);
      chk("bp ascii held", ev_ascii, 8'h31);
      chk("bp make_count", make_count, 8'd9);
      kb_overflow = 1'b1;
      @(negedge clk);
      kb_overflow = 1'b0;
      chk("ovf set", ovf_err, 1'b1);
      err_clr = 1'b1; kb_overflow = 1'b1;
      @(negedge clk);
      err_clr = 1'b0; kb_overflow = 1'b0;
      chk("ovf wins over clr", ovf_err, 1'b1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("ovf cleared", ovf_err, 1'b0);
      kb_overflow = 1'b1;
      @(negedge clk);
      kb_overflow = 1'b0;

      // Async reset mid-EMIT
      clrn = 1'b0;
      #1;
      chk("mid rst ev_valid",   ev_valid,   1'b0);
      chk("mid rst nextdata_n", nextdata_n, 1'b1);
      chk("mid rst ev_code",    ev_code,    8'h00);
      chk("mid rst ev_ascii",   ev_ascii,   8'h00);
      chk("mid rst ev_make",    ev_make,    1'b0);
      chk("mid rst make_count", make_count, 8'h00);
      chk("mid rst caps",       caps_lock,  1'b0);
      chk("mid rst rom_addr",   rom_addr,   8'h00);
      chk("mid rst ovf_err",    ovf_err,    1'b0);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
